// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port MIPS register file: default geometry
// and the write-port priority used when both ports target one register.
package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREGS = 32;

  // On a same-register collision, write port 1 overrides write port 0.
  localparam bit WR1_OVER_WR0 = 1'b1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets a bit, any write to that register
// clears it (issue wins a same-cycle tie), with two busy read ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] issue_regnum,
  input  logic          issue_enable,
  input  logic [AW-1:0] wr0_regnum,
  input  logic          wr0_enable,
  input  logic [AW-1:0] wr1_regnum,
  input  logic          wr1_enable,
  input  logic [AW-1:0] rd1_regnum,
  input  logic [AW-1:0] rd2_regnum,
  output logic          rd1_busy,
  output logic          rd2_busy,
  output logic          any_busy
);

  localparam bit ZERO_ON = (ZERO_REG != 0);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int r = 0; r < NREGS; r++) begin
      if (!(ZERO_ON && r == 0)) begin
        set_vec[r] = issue_enable && (issue_regnum == AW'(r));
        clr_vec[r] = (wr0_enable && (wr0_regnum == AW'(r))) ||
                     (wr1_enable && (wr1_regnum == AW'(r)));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_vec) | set_vec;
    end
  end

  assign rd1_busy = busy[rd1_regnum];
  assign rd2_busy = busy[rd2_regnum];
  assign any_busy = |busy;

endmodule

// File: rtl/mips_regfile_mp.sv
// Two-write / two-read MIPS register file with busy scoreboard.
// Optional same-cycle write-to-read forwarding under REGFILE_BYPASS_EN.
module mips_regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NREGS    = DEF_NREGS,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rd1_regnum,
  input  logic [AW-1:0]    rd2_regnum,
  output logic [WIDTH-1:0] rd1_data,
  output logic [WIDTH-1:0] rd2_data,
  output logic             rd1_busy,
  output logic             rd2_busy,
  input  logic [AW-1:0]    wr0_regnum,
  input  logic [AW-1:0]    wr1_regnum,
  input  logic [WIDTH-1:0] wr0_data,
  input  logic [WIDTH-1:0] wr1_data,
  input  logic             wr0_enable,
  input  logic             wr1_enable,
  input  logic [AW-1:0]    issue_regnum,
  input  logic             issue_enable,
  output logic             any_busy
);

  localparam bit ZERO_ON = (ZERO_REG != 0);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] we0;
  logic [NREGS-1:0] we1;
  logic             sb_busy1;
  logic             sb_busy2;

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .issue_regnum (issue_regnum),
    .issue_enable (issue_enable),
    .wr0_regnum   (wr0_regnum),
    .wr0_enable   (wr0_enable),
    .wr1_regnum   (wr1_regnum),
    .wr1_enable   (wr1_enable),
    .rd1_regnum   (rd1_regnum),
    .rd2_regnum   (rd2_regnum),
    .rd1_busy     (sb_busy1),
    .rd2_busy     (sb_busy2),
    .any_busy     (any_busy)
  );

  // Write arbitration: at most one port's data lands in each register.
  always_comb begin
    logic h0;
    logic h1;
    we0 = '0;
    we1 = '0;
    h0  = 1'b0;
    h1  = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (!(ZERO_ON && r == 0)) begin
        h0     = wr0_enable && (wr0_regnum == AW'(r));
        h1     = wr1_enable && (wr1_regnum == AW'(r));
        we1[r] = h1 && (WR1_OVER_WR0 || !h0);
        we0[r] = h0 && !we1[r];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (we1[r])      regs[r] <= wr1_data;
        else if (we0[r]) regs[r] <= wr0_data;
      end
    end
  end

  // Read ports; with forwarding, a write in flight to the addressed
  // register is visible now and its busy bit reads as already cleared.
  always_comb begin
    rd1_data = regs[rd1_regnum];
    rd2_data = regs[rd2_regnum];
    rd1_busy = sb_busy1;
    rd2_busy = sb_busy2;
`ifdef REGFILE_BYPASS_EN
    if (we1[rd1_regnum]) begin
      rd1_data = wr1_data;
      rd1_busy = issue_enable && (issue_regnum == rd1_regnum);
    end else if (we0[rd1_regnum]) begin
      rd1_data = wr0_data;
      rd1_busy = issue_enable && (issue_regnum == rd1_regnum);
    end
    if (we1[rd2_regnum]) begin
      rd2_data = wr1_data;
      rd2_busy = issue_enable && (issue_regnum == rd2_regnum);
    end else if (we0[rd2_regnum]) begin
      rd2_data = wr0_data;
      rd2_busy = issue_enable && (issue_regnum == rd2_regnum);
    end
`endif
  end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed bench for mips_regfile_mp: default 32x32 instance with zero
// register, plus an 8x8 instance without zero register.
module tb_mips_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;

  logic [4:0]  rd1_regnum, rd2_regnum, wr0_regnum, wr1_regnum, issue_regnum;
  logic [31:0] rd1_data, rd2_data, wr0_data, wr1_data;
  logic        rd1_busy, rd2_busy, wr0_enable, wr1_enable, issue_enable, any_busy;

  logic [2:0]  s_rd1_regnum, s_rd2_regnum, s_wr0_regnum, s_wr1_regnum, s_issue_regnum;
  logic [7:0]  s_rd1_data, s_rd2_data, s_wr0_data, s_wr1_data;
  logic        s_rd1_busy, s_rd2_busy, s_wr0_enable, s_wr1_enable, s_issue_enable, s_any_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_regfile_mp dut (
    .clk(clk), .reset(reset),
    .rd1_regnum(rd1_regnum), .rd2_regnum(rd2_regnum),
    .rd1_data(rd1_data), .rd2_data(rd2_data),
    .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
    .wr0_regnum(wr0_regnum), .wr1_regnum(wr1_regnum),
    .wr0_data(wr0_data), .wr1_data(wr1_data),
    .wr0_enable(wr0_enable), .wr1_enable(wr1_enable),
    .issue_regnum(issue_regnum), .issue_enable(issue_enable),
    .any_busy(any_busy)
  );

  mips_regfile_mp #(.WIDTH(8), .NREGS(8), .ZERO_REG(0)) dut8 (
    .clk(clk), .reset(reset),
    .rd1_regnum(s_rd1_regnum), .rd2_regnum(s_rd2_regnum),
    .rd1_data(s_rd1_data), .rd2_data(s_rd2_data),
    .rd1_busy(s_rd1_busy), .rd2_busy(s_rd2_busy),
    .wr0_regnum(s_wr0_regnum), .wr1_regnum(s_wr1_regnum),
    .wr0_data(s_wr0_data), .wr1_data(s_wr1_data),
    .wr0_enable(s_wr0_enable), .wr1_enable(s_wr1_enable),
    .issue_regnum(s_issue_regnum), .issue_enable(s_issue_enable),
    .any_busy(s_any_busy)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_enable = 0; wr1_enable = 0; issue_enable = 0;
    s_wr0_enable = 0; s_wr1_enable = 0; s_issue_enable = 0;
  endtask

  initial begin
    reset = 1;
    rd1_regnum = 0; rd2_regnum = 0; wr0_regnum = 0; wr1_regnum = 0; issue_regnum = 0;
    wr0_data = 0; wr1_data = 0;
    s_rd1_regnum = 0; s_rd2_regnum = 0; s_wr0_regnum = 0; s_wr1_regnum = 0; s_issue_regnum = 0;
    s_wr0_data = 0; s_wr1_data = 0;
    idle();
    step(); step();
    reset = 0;
    rd1_regnum = 9; rd2_regnum = 17;
    #1;
    check_vec("reset_rd1_data", rd1_data, 32'd0);
    check_vec("reset_rd2_data", rd2_data, 32'd0);
    check_vec("reset_rd1_busy", {31'd0, rd1_busy}, 32'd0);
    check_vec("reset_any_busy", {31'd0, any_busy}, 32'd0);

    // basic write, both ports read same register
    wr0_regnum = 2; wr0_data = 88; wr0_enable = 1;
    step(); idle();
    rd1_regnum = 2; rd2_regnum = 2; #1;
    check_vec("wr_r2_rd1", rd1_data, 32'd88);
    check_vec("wr_r2_rd2", rd2_data, 32'd88);

    // collision: wr1 wins
    wr0_regnum = 1; wr0_data = 32'hF; wr0_enable = 1;
    wr1_regnum = 1; wr1_data = 32'hD; wr1_enable = 1;
    step(); idle();
    rd1_regnum = 1; #1;
    check_vec("collide_r1", rd1_data, 32'hD);

    // independent dual write
    wr0_regnum = 3; wr0_data = 32'hB; wr0_enable = 1;
    wr1_regnum = 4; wr1_data = 32'h3; wr1_enable = 1;
    step(); idle();
    rd1_regnum = 3; rd2_regnum = 4; #1;
    check_vec("dual_r3", rd1_data, 32'hB);
    check_vec("dual_r4", rd2_data, 32'h3);

    // hardwired zero register
    wr0_regnum = 0; wr0_data = 32'h55; wr0_enable = 1;
    issue_regnum = 0; issue_enable = 1;
    step(); idle();
    rd1_regnum = 0; #1;
    check_vec("zero_data", rd1_data, 32'd0);
    check_vec("zero_busy", {31'd0, rd1_busy}, 32'd0);
    check_vec("zero_any_busy", {31'd0, any_busy}, 32'd0);

    // issue then clear by write
    issue_regnum = 5; issue_enable = 1;
    step(); idle();
    rd1_regnum = 5; #1;
    check_vec("issue_r5_busy", {31'd0, rd1_busy}, 32'd1);
    check_vec("issue_any_busy", {31'd0, any_busy}, 32'd1);
    wr0_regnum = 5; wr0_data = 7; wr0_enable = 1;
    step(); idle(); #1;
    check_vec("clr_r5_busy", {31'd0, rd1_busy}, 32'd0);
    check_vec("clr_r5_data", rd1_data, 32'd7);
    check_vec("clr_any_busy", {31'd0, any_busy}, 32'd0);

    // issue and write same register same cycle: issue wins busy, data written
    issue_regnum = 6; issue_enable = 1;
    wr1_regnum = 6; wr1_data = 9; wr1_enable = 1;
    step(); idle();
    rd1_regnum = 6; #1;
    check_vec("iw_r6_busy", {31'd0, rd1_busy}, 32'd1);
    check_vec("iw_r6_data", rd1_data, 32'd9);

    // same-cycle read of a register being written
    rd2_regnum = 7; wr0_regnum = 7; wr0_data = 32'h1234; wr0_enable = 1;
    #1;
`ifdef REGFILE_BYPASS_EN
    check_vec("byp_same_cycle", rd2_data, 32'h1234);
`else
    check_vec("nobyp_same_cycle", rd2_data, 32'd0);
`endif
    step(); idle(); #1;
    check_vec("wr_r7_next", rd2_data, 32'h1234);

    // asynchronous reset mid-cycle with a write pending across the edge
    rd1_regnum = 2; rd2_regnum = 6;
    wr0_regnum = 2; wr0_data = 32'hABCD; wr0_enable = 1;
    issue_regnum = 8; issue_enable = 1;
    #2 reset = 1;
    #1;
    check_vec("async_rst_rd1", rd1_data, 32'd0);
    check_vec("async_rst_rd2", rd2_data, 32'd0);
    check_vec("async_rst_busy", {31'd0, rd2_busy}, 32'd0);
    check_vec("async_rst_any", {31'd0, any_busy}, 32'd0);
    step();
    reset = 0; idle(); #1;
    check_vec("rst_edge_wr_ignored", rd1_data, 32'd0);
    check_vec("rst_edge_issue_ignored", {31'd0, any_busy}, 32'd0);

    // 8x8 instance: full-scale data, regnum at top of range, ordinary r0
    s_wr0_regnum = 3'd7; s_wr0_data = 8'hFF; s_wr0_enable = 1;
    s_wr1_regnum = 3'd0; s_wr1_data = 8'h5A; s_wr1_enable = 1;
    s_issue_regnum = 3'd0; s_issue_enable = 1;
    step(); idle();
    s_rd1_regnum = 3'(15); s_rd2_regnum = 3'd0; #1;
    check_vec("w8_r7_data", {24'd0, s_rd1_data}, 32'hFF);
    check_vec("w8_r0_data", {24'd0, s_rd2_data}, 32'h5A);
    check_vec("w8_r0_busy", {31'd0, s_rd2_busy}, 32'd1);
    check_vec("w8_any_busy", {31'd0, s_any_busy}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
